data_mem_wbuf: RTL
==================

# data_mem_wbuf

Data-memory front end that sits directly downstream of the pipelined CPU's MEM stage. It accepts STORE writes and LOAD reads from the CPU and returns load data on `mem_store_data`. It owns the only port of a single-port synchronous data SRAM. Stores are absorbed into a small write buffer and drained to the SRAM in idle cycles, and loads get priority at the SRAM with read-after-write forwarding from the buffer. The CPU has no stall input, so the block never back-pressures.

## Interface
- `DEPTH`, 4: write-buffer entries; power of two, at least 2.
- `AW`, 11: address width.
- `DW`, 32: data width.

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `write_mem`  in  1  store request from the CPU this cycle
- `mem_wadrs`  in  AW  store address
- `mem_wdata`  in  DW  store data
- `read_mem_str`  in  1  load request from the CPU this cycle
- `mem_radrs_LD`  in  AW  load address
- `mem_store_data`  out  DW  load data returned to the CPU
- `sram_en`  out  1  SRAM access enable (combinational)
- `sram_we`  out  1  SRAM write enable (combinational)
- `sram_addr`  out  AW  SRAM address (combinational)
- `sram_wdata`  out  DW  SRAM write data (combinational)
- `sram_rdata`  in  DW  SRAM read data, valid in the cycle after a read with `sram_en=1, sram_we=0`
- `wbuf_count`  out  log2(DEPTH)+1  number of occupied buffer entries
- `wbuf_full`  out  1  `wbuf_count == DEPTH`
- `wbuf_empty`  out  1  `wbuf_count == 0`
- `rd_conflict`  out  1  sticky error flag; see below

## Operation
- **Write buffer.** Circular FIFO of {addr, data} with head and tail pointers that wrap modulo DEPTH. No coalescing: repeated stores to one address occupy separate entries. Drain order is oldest first.
- **SRAM arbitration.** One SRAM access per cycle. Priority, decided on the current inputs and buffer state:
  1. Buffer full: drain the head entry.
  2. Otherwise, `read_mem_str`: SRAM read of `mem_radrs_LD`.
  3. Otherwise, buffer not empty: drain the head entry.
  4. Otherwise: `sram_en=0`.
- **Enqueue.** `write_mem` always enqueues at the clock edge. When the buffer is full, the same-cycle drain frees the slot, so the count stays at DEPTH. Enqueue and drain in the same cycle leave the count unchanged.
- **Forwarding.** A load address is compared against every valid entry and against the incoming store of the same cycle.
  - Priority on a match: the incoming store wins, otherwise the newest buffer entry.
  - On a hit, the forwarded data is registered. The SRAM is still read under rule 2 but its result is ignored.
- **Load result.**
  - A registered select flag picks `mem_store_data` = forwarded register or `sram_rdata`.
  - After each load it is held until the next load. The block captures `sram_rdata` into a hold register in the cycle after a miss so it stays stable.
- **Conflict.** A load that misses the buffer in a cycle where rule 1 applies cannot be served.
  - The block returns 0 for that load.
  - It sets `rd_conflict=1`. The flag is sticky until reset.
- **Reset (asynchronous).**
  - Pointers and count go to 0, so `wbuf_empty=1` and `wbuf_full=0`. Entries are discarded.
  - Hold register = 0, select = hold, so `mem_store_data=0`.
  - `rd_conflict=0`. With the buffer empty and no requests, `sram_en=0`.
  - A reset during a drain abandons the buffer contents. The SRAM keeps any write already issued.

## Timing
- Load issued in cycle N: `mem_store_data` is valid throughout cycle N+1 (sampled at the end of N+1) and held afterwards.
- Store issued in cycle N: visible to loads from cycle N onward, through same-cycle forwarding.
- Store drain latency: at least 1 cycle after enqueue, and unbounded while loads occupy every cycle and the buffer is not full.
- `wbuf_count`, `wbuf_full` and `wbuf_empty` are registered and update at the edge after enqueue or drain.
- The SRAM interface outputs are combinational from registered state and the CPU request inputs.

## Test plan
1. **Reset, then idle.** Expect `mem_store_data=0`, `wbuf_empty=1`, `sram_en=0` and `rd_conflict=0`.
2. **Simple store then load.** Store 0x12345678 to 0x005 in cycle 0, idle in cycle 1, load 0x005 in cycle 2.
   - Cycle 1: SRAM write to 0x005 is seen.
   - Cycle 3: `mem_store_data=0x12345678` via the SRAM path.
3. **Same-cycle forwarding.** Store 0xAAAA0001 to 0x010 and load 0x010 in the same cycle. Expect 0xAAAA0001 in the next cycle, and no SRAM write yet.
4. **Newest match wins.**
   - Stores 0x1, 0x2, 0x3 to 0x020 go out on consecutive cycles, each cycle also carrying a load to an unrelated address, so nothing drains.
   - A load of 0x020 in the following cycle returns 3.
   - After idling, the SRAM sees writes 1, 2, 3 in order.
5. **Buffer full.** DEPTH stores interleaved with loads reach `wbuf_full=1`. The next store with no load forces a drain of the oldest entry while `wbuf_count` stays at 4.
6. **Full-buffer conflict.** With the buffer full, a load to an address that is not in the buffer returns 0 and sets `rd_conflict=1`. An async reset asserted mid-drain then clears the count and the flag immediately.

Source files
------------

// File: rtl/data_mem_wbuf.sv
// Data-memory front end: posted-write buffer in front of a single-port synchronous SRAM.
// Loads take priority at the SRAM and are forwarded from the buffer or the same-cycle store.
module data_mem_wbuf #(
  parameter int DEPTH = 4,
  parameter int AW    = 11,
  parameter int DW    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   write_mem,
  input  logic [AW-1:0]          mem_wadrs,
  input  logic [DW-1:0]          mem_wdata,
  input  logic                   read_mem_str,
  input  logic [AW-1:0]          mem_radrs_LD,
  output logic [DW-1:0]          mem_store_data,
  output logic                   sram_en,
  output logic                   sram_we,
  output logic [AW-1:0]          sram_addr,
  output logic [DW-1:0]          sram_wdata,
  input  logic [DW-1:0]          sram_rdata,
  output logic [$clog2(DEPTH):0] wbuf_count,
  output logic                   wbuf_full,
  output logic                   wbuf_empty,
  output logic                   rd_conflict
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {SEL_HOLD, SEL_FWD, SEL_SRAM} sel_e;

  logic [AW-1:0] buf_addr [DEPTH];
  logic [DW-1:0] buf_data [DEPTH];
  logic [PW-1:0] head_q, tail_q;

  sel_e          sel_q;
  logic [DW-1:0] hold_q, fwd_q;

  logic          drain, do_read;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;

  assign wbuf_full  = (wbuf_count == CW'(DEPTH));
  assign wbuf_empty = (wbuf_count == '0);

  // A full buffer always drains so an incoming store never overflows it.
  assign drain   = wbuf_full || (!read_mem_str && !wbuf_empty);
  assign do_read = read_mem_str && !wbuf_full;

  assign sram_en    = drain || do_read;
  assign sram_we    = drain;
  assign sram_addr  = drain ? buf_addr[head_q] : mem_radrs_LD;
  assign sram_wdata = buf_data[head_q];

  // NOTE: every variable gets a default before any conditional assignment so no latch is inferred.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    // Scan oldest to newest so the newest matching entry overrides older ones.
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < wbuf_count) && (buf_addr[head_q + PW'(k)] == mem_radrs_LD)) begin
        fwd_hit  = 1'b1;
        fwd_data = buf_data[head_q + PW'(k)];
      end
    end
    if (write_mem && (mem_wadrs == mem_radrs_LD)) begin
      fwd_hit  = 1'b1;
      fwd_data = mem_wdata;
    end
  end

  // NOTE: buffer storage is not reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (write_mem) begin
      buf_addr[tail_q] <= mem_wadrs;
      buf_data[tail_q] <= mem_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      wbuf_count <= '0;
    end else begin
      if (write_mem) tail_q <= tail_q + 1'b1;
      if (drain)     head_q <= head_q + 1'b1;
      wbuf_count <= wbuf_count + CW'(write_mem) - CW'(drain);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q      <= '0;
      fwd_q       <= '0;
      sel_q       <= SEL_HOLD;
      rd_conflict <= 1'b0;
    end else begin
      if (sel_q == SEL_SRAM) hold_q <= sram_rdata;
      if (read_mem_str) begin
        if (fwd_hit) begin
          fwd_q <= fwd_data;
          sel_q <= SEL_FWD;
        end else if (wbuf_full) begin
          // The SRAM is busy draining, so this load cannot be served.
          fwd_q       <= '0;
          sel_q       <= SEL_FWD;
          rd_conflict <= 1'b1;
        end else begin
          sel_q <= SEL_SRAM;
        end
      end else if (sel_q == SEL_SRAM) begin
        sel_q <= SEL_HOLD;
      end
    end
  end

  always_comb begin
    case (sel_q)
      SEL_FWD:  mem_store_data = fwd_q;
      SEL_SRAM: mem_store_data = sram_rdata;
      default:  mem_store_data = hold_q;
    endcase
  end

endmodule
